// File: rtl/div_seq_pkg.sv
// Shared constants and types for the sequential restoring divider.
package div_seq_pkg;

  localparam int W_DEFAULT = 123;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for a given operand width (2W steps, counted 2W-1 down to 0).
  function automatic int cnt_w(input int w);
    return $clog2(2 * w);
  endfunction

  localparam int CNT_W = $clog2(2 * W_DEFAULT);

endpackage

// File: rtl/div_seq_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step
  import div_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W:0]   p,
  input  logic         dvd_msb,
  input  logic [W-1:0] divisor,
  output logic [W:0]   p_next,
  output logic         qbit
);

  logic [W:0] t;
  logic [W:0] diff;
  logic       borrow;

  always_comb begin
    t             = {p[W-1:0], dvd_msb};
    {borrow, diff} = {1'b0, t} - {2'b0, divisor};
    // P stays below the divisor, so p[W] is zero; folding it in keeps the
    // compare exact for the full shifted value {p, dvd_msb}.
    qbit   = p[W] | ~borrow;
    p_next = qbit ? diff : t;
  end

endmodule

// File: rtl/div_seq.sv
// Sequential 2W/W unsigned divider: one quotient bit per clock, valid/ready on both sides.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] DIVIDEND,
  input  logic [W-1:0]   DIVISOR,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] QUOTIENT,
  output logic [W-1:0]   REMAINDER,
  output logic           DIV_BY_ZERO
);

  localparam int CW = cnt_w(W);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] dvd;   // dividend bits shift out the top, quotient bits in the bottom
  logic [W-1:0]   dsr;
  logic [W:0]     p;
  logic           dbz;

  logic [W:0]     p_next;
  logic           qbit;

  div_step #(.W(W)) u_step (
    .p       (p),
    .dvd_msb (dvd[2*W-1]),
    .divisor (dsr),
    .p_next  (p_next),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      p         <= '0;
      dbz       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dsr      <= DIVISOR;
            p        <= '0;
            in_ready <= 1'b0;
            if (DIVISOR == '0) begin
              dvd       <= '1;
              dbz       <= 1'b1;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              dvd   <= DIVIDEND;
              dbz   <= 1'b0;
              cnt   <= CW'(2 * W - 1);
              state <= RUN;
            end
          end
        end
        RUN: begin
          dvd <= {dvd[2*W-2:0], qbit};
          p   <= p_next;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign QUOTIENT    = dvd;
  assign REMAINDER   = p[W-1:0];
  assign DIV_BY_ZERO = dbz;

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter W, default 123, sets the operand width; dividend and quotient are 2*W bits, divisor and remainder are W bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  DIVIDEND/DIVISOR valid this cycle.
REQ-005 in_ready  output  1  block can accept an operand pair this cycle.
REQ-006 DIVIDEND  input  2*W  unsigned dividend, sized to take a full 2W-bit product.
REQ-007 DIVISOR  input  W  unsigned divisor.
REQ-008 out_valid  output  1  QUOTIENT/REMAINDER/DIV_BY_ZERO valid.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 QUOTIENT  output  2*W  floor(DIVIDEND/DIVISOR).
REQ-011 REMAINDER  output  W  DIVIDEND mod DIVISOR.
REQ-012 DIV_BY_ZERO  output  1  the accepted DIVISOR was zero.

Function
REQ-013 FSM states are IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 Input handshake: when in_valid and in_ready are both 1 at an edge, the block SHALL capture DIVIDEND and DIVISOR. If DIVISOR is nonzero it SHALL load counter=2W-1 and enter RUN; if DIVISOR is zero it SHALL enter DONE.
REQ-015 RUN performs radix-2 restoring division, one quotient bit per edge, MSB first, using partial remainder P (W+1 bits). Each step: T={P[W-1:0], dividend MSB}; if T>=divisor, P=T-divisor and qbit=1, else P=T and qbit=0; the dividend register shifts left with qbit inserted at the LSB.
REQ-016 On the RUN edge where counter==0, the block SHALL enter DONE. Latency is exactly 2W edges from the acceptance edge to out_valid (246 for W=123), independent of operand values.
REQ-017 Divide-by-zero: out_valid SHALL rise the cycle after acceptance, with QUOTIENT all-ones, REMAINDER zero and DIV_BY_ZERO=1.
REQ-018 DIV_BY_ZERO SHALL be 0 for every nonzero-divisor result.
REQ-019 Output handshake: in DONE, QUOTIENT, REMAINDER and DIV_BY_ZERO SHALL hold stable until out_valid and out_ready are both 1 at an edge; the block SHALL then return to IDLE.
REQ-020 in_ready SHALL be asserted no earlier than the cycle after the output handshake; there is no same-cycle turnaround.
REQ-021 in_valid SHALL be ignored outside IDLE, and the inputs need not be held after acceptance.
REQ-022 A zero dividend with a nonzero divisor SHALL still take the full 2W cycles and yield quotient 0, remainder 0.

Reset
REQ-023 rst_n=0 at an edge SHALL force IDLE, counter=0, and all data registers to 0 from any state, including mid-RUN and DONE; any in-flight result is discarded.
REQ-024 Reset values: in_ready=1, out_valid=0, QUOTIENT=0, REMAINDER=0, DIV_BY_ZERO=0.
REQ-025 An in_valid coinciding with rst_n=0 SHALL NOT be accepted.

Structure
REQ-026 A shared package SHALL hold W's default, the state enum (IDLE/RUN/DONE) and the counter width constant, $clog2(2*W).
REQ-027 The combinational compare/subtract/shift of REQ-015 SHALL be a sub-module named div_step, instantiated once; div_seq holds the FSM, counter and registers.
REQ-028 No DSP inference; the datapath is a single W+1-bit subtractor plus registers.

Verification
REQ-029 DIVIDEND=100, DIVISOR=7 -> after 246 cycles QUOTIENT=14, REMAINDER=2, DIV_BY_ZERO=0.
REQ-030 DIVIDEND=(2^123-1)^2, DIVISOR=2^123-1 -> QUOTIENT=2^123-1, REMAINDER=0; also DIVIDEND=2^246-1, DIVISOR=1 -> QUOTIENT all-ones, REMAINDER=0.
REQ-031 DIVISOR=0, any DIVIDEND -> out_valid the next cycle, QUOTIENT all-ones, REMAINDER=0, DIV_BY_ZERO=1.
REQ-032 Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, and in_valid pulses ignored; the handshake then completes and in_ready=1 the following cycle.
REQ-033 Assert rst_n=0 at cycle 100 of RUN -> next cycle out_valid=0 and in_ready=1; a new op 50/5 then yields QUOTIENT=10, REMAINDER=0.
REQ-034 A random regression of 10k operand pairs SHALL check QUOTIENT*DIVISOR+REMAINDER==DIVIDEND and REMAINDER<DIVISOR.
